// File: rtl/rv32v_types_pkg.sv
// rtl/rv32v_types_pkg.sv - shared types for the vector element sequencer
package rv32v_types_pkg;
  localparam int NUM_LANES = 2;
  localparam int VL_WIDTH  = 5;

  typedef logic [VL_WIDTH:0]   offset_t;
  // One extra bit so offset+NUM_LANES can never wrap in the last-beat test
  typedef logic [VL_WIDTH+1:0] offset_wide_t;
  typedef logic [NUM_LANES-1:0] lane_mask_t;

  typedef enum logic [1:0] {SEW8 = 2'd0, SEW16, SEW32, SEW64} sew_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN, DRAIN} seq_state_t;

  typedef struct packed {
    logic       valid;
    offset_t    offset;
    lane_mask_t mask;
  } wb_beat_t;
endpackage

// File: rtl/rv32v_wb_delay_line.sv
// rtl/rv32v_wb_delay_line.sv - fixed-latency shift register of writeback beats
module rv32v_wb_delay_line
  import rv32v_types_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_clr,
  input  wb_beat_t i_beat,
  output wb_beat_t o_beat,
  output logic     o_pending
);
  wb_beat_t r_stage [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else begin
      r_stage[0] <= i_beat;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
      if (i_clr) begin
        for (int k = 0; k < DEPTH; k++) r_stage[k].valid <= 1'b0;
      end
    end
  end

  // Beats still upstream of the output stage; the output stage itself is being written this cycle
  always_comb begin
    o_pending = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) o_pending = o_pending | r_stage[k].valid;
  end

  assign o_beat = r_stage[DEPTH-1];
endmodule

// File: rtl/rv32v_elem_sequencer.sv
// rtl/rv32v_elem_sequencer.sv - walks one vector instruction through the VRF, NUM_LANES elements per beat
module rv32v_elem_sequencer
  import rv32v_types_pkg::*;
#(
  parameter int WB_LATENCY = 2
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                start,
  output logic                start_ready,
  input  logic [VL_WIDTH:0]   vl_in,
  input  sew_t                sew_in,
  input  sew_t                eew_in,
  input  logic                wr_en_in,
  input  logic                stall,
  input  logic                flush,
  output logic                rd_valid,
  output offset_t             rd_offset,
  output logic [NUM_LANES-1:0] rd_mask,
  output sew_t                sew,
  output sew_t                eew,
  output logic [VL_WIDTH:0]   vl,
  output offset_t             vd_offset,
  output logic [NUM_LANES-1:0] wb_mask,
  output logic                wen,
  output logic                busy,
  output logic                done
);
  seq_state_t        r_state;
  offset_t           r_offset;
  logic [VL_WIDTH:0] r_vl;
  sew_t              r_sew;
  sew_t              r_eew;
  logic              r_wr_en;
  logic              r_done;

  seq_state_t   w_next_state;
  logic         w_load;
  logic         w_accept;
  logic         w_finish;
  logic         w_last;
  logic         w_pending;
  offset_wide_t w_sum;
  lane_mask_t   w_rd_mask;
  wb_beat_t     w_push;
  wb_beat_t     w_wb;

  assign w_sum  = offset_wide_t'(r_offset) + offset_wide_t'(NUM_LANES);
  assign w_last = (w_sum >= offset_wide_t'(r_vl));

  always_comb begin
    w_rd_mask = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_rd_mask[i] = (r_state == RUN) &&
                     ((offset_wide_t'(r_offset) + offset_wide_t'(i)) < offset_wide_t'(r_vl));
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_next_state = (vl_in != '0) ? RUN : DRAIN;
        end
      end
      RUN: begin
        w_accept = !stall;
        if (w_accept && w_last) w_next_state = DRAIN;
      end
      DRAIN: begin
        // Leave as the final beat reaches the output stage so done lands one cycle after it
        if (!w_pending) begin
          w_next_state = IDLE;
          w_finish     = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
    if (flush) begin
      w_next_state = IDLE;
      w_load       = 1'b0;
      w_accept     = 1'b0;
      w_finish     = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_offset <= '0;
      r_vl     <= '0;
      r_sew    <= SEW32;
      r_eew    <= SEW32;
      r_wr_en  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_finish;
      if (w_load) begin
        r_offset <= '0;
        r_vl     <= vl_in;
        r_sew    <= sew_in;
        r_eew    <= eew_in;
        r_wr_en  <= wr_en_in;
      end else if (w_accept) begin
        r_offset <= w_sum[VL_WIDTH:0];
      end
    end
  end

  assign w_push = '{valid: w_accept, offset: r_offset, mask: w_rd_mask};

  rv32v_wb_delay_line #(.DEPTH(WB_LATENCY)) u_wb_delay (
    .i_clk    (CLK),
    .i_rst_n  (nRST),
    .i_clr    (flush),
    .i_beat   (w_push),
    .o_beat   (w_wb),
    .o_pending(w_pending)
  );

  assign start_ready = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign rd_valid    = (r_state == RUN);
  assign rd_offset   = r_offset;
  assign rd_mask     = w_rd_mask;
  assign sew         = r_sew;
  assign eew         = r_eew;
  assign vl          = r_vl;
  assign vd_offset   = w_wb.offset;
  assign wb_mask     = w_wb.mask;
  assign wen         = w_wb.valid & r_wr_en;
  assign done        = r_done;
endmodule

// File: tb/tb_rv32v_elem_sequencer.sv
// tb/tb_rv32v_elem_sequencer.sv - directed table-driven bench for rv32v_elem_sequencer
module tb_rv32v_elem_sequencer;
  import rv32v_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        start;
  logic        start_ready;
  logic [5:0]  vl_in;
  sew_t        sew_in;
  sew_t        eew_in;
  logic        wr_en_in;
  logic        stall;
  logic        flush;
  logic        rd_valid;
  offset_t     rd_offset;
  logic [1:0]  rd_mask;
  sew_t        sew;
  sew_t        eew;
  logic [5:0]  vl;
  offset_t     vd_offset;
  logic [1:0]  wb_mask;
  logic        wen;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  rv32v_elem_sequencer #(.WB_LATENCY(2)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .start_ready(start_ready),
    .vl_in(vl_in), .sew_in(sew_in), .eew_in(eew_in), .wr_en_in(wr_en_in),
    .stall(stall), .flush(flush), .rd_valid(rd_valid), .rd_offset(rd_offset),
    .rd_mask(rd_mask), .sew(sew), .eew(eew), .vl(vl), .vd_offset(vd_offset),
    .wb_mask(wb_mask), .wen(wen), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       st;
    logic [5:0] vli;
    logic       wr;
    logic       stl;
    logic       fl;
    logic       rv;
    logic [5:0] ro;
    logic [1:0] rm;
    logic       we;
    logic [5:0] vo;
    logic [1:0] wm;
    logic       dn;
    logic       bz;
    logic       sr;
    logic [5:0] vlo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic [5:0] vli, logic wr, logic stl, logic fl,
                              logic rv, logic [5:0] ro, logic [1:0] rm,
                              logic we, logic [5:0] vo, logic [1:0] wm,
                              logic dn, logic bz, logic sr, logic [5:0] vlo);
    vec_t v;
    v.st = st; v.vli = vli; v.wr = wr; v.stl = stl; v.fl = fl;
    v.rv = rv; v.ro = ro; v.rm = rm; v.we = we; v.vo = vo; v.wm = wm;
    v.dn = dn; v.bz = bz; v.sr = sr; v.vlo = vlo;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [5:0] vli, input logic wr,
                       input logic stl, input logic fl);
    start = st; vl_in = vli; wr_en_in = wr; stall = stl; flush = fl;
  endtask

  initial begin
    logic [26:0] got_v;
    logic [26:0] exp_v;

    nRST = 1'b0;
    sew_in = SEW16;
    eew_in = SEW8;
    drive(0, 6'd0, 0, 0, 0);

    // start  vl wr stl fl | rv ro rm | we vo wm | dn bz sr | vl
    vecs.push_back(mk(1, 5, 1, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 1,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 3,  0, 0, 0,  0, 1, 0,  5));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 2, 3,  0, 0, 0,  0, 1, 0,  5));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 4, 1,  1, 0, 3,  0, 1, 0,  5));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 2, 3,  0, 1, 0,  5));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 4, 1,  0, 1, 0,  5));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 1,  5));
    // vl=0: no beats, done two cycles after start
    vecs.push_back(mk(1, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 1,  5));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 1, 0,  0));
    // start coincident with done; wr_en=0, vl=3
    vecs.push_back(mk(1, 3, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 1,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 3,  0, 0, 0,  0, 1, 0,  3));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 2, 1,  0, 0, 0,  0, 1, 0,  3));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 1, 0,  3));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 1, 0,  3));
    // vl=4 with a 3-cycle stall on the second beat
    vecs.push_back(mk(1, 4, 1, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 1,  3));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 3,  0, 0, 0,  0, 1, 0,  4));
    vecs.push_back(mk(0, 0, 0, 1, 0,  1, 2, 3,  0, 0, 0,  0, 1, 0,  4));
    vecs.push_back(mk(0, 0, 0, 1, 0,  1, 2, 3,  1, 0, 3,  0, 1, 0,  4));
    vecs.push_back(mk(0, 0, 0, 1, 0,  1, 2, 3,  0, 0, 0,  0, 1, 0,  4));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 2, 3,  0, 0, 0,  0, 1, 0,  4));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 1, 0,  4));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 2, 3,  0, 1, 0,  4));
    // vl=6 flushed on the second beat, then vl=2 restarts right after
    vecs.push_back(mk(1, 6, 1, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 1,  4));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 3,  0, 0, 0,  0, 1, 0,  6));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 2, 3,  0, 0, 0,  0, 1, 0,  6));
    vecs.push_back(mk(1, 2, 1, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 1,  6));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 3,  0, 0, 0,  0, 1, 0,  2));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 1, 0,  2));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 0, 3,  0, 1, 0,  2));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 1,  2));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 1,  2));

    repeat (2) @(negedge CLK);
    #1;
    check("reset_outputs", {27'b0, rd_valid, wen, done, busy, start_ready}, 32'h1);
    check("reset_fields", {12'b0, rd_offset, vd_offset, rd_mask, wb_mask},  32'h0);
    check("reset_vl", {26'b0, vl}, 32'h0);
    check("reset_sew_eew", {28'b0, sew, eew}, {28'b0, SEW32, SEW32});
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      drive(vecs[i].st, vecs[i].vli, vecs[i].wr, vecs[i].stl, vecs[i].fl);
      #1;
      got_v = {rd_valid, vecs[i].rv ? rd_offset : 6'd0, vecs[i].rv ? rd_mask : 2'd0,
               wen, vecs[i].we ? vd_offset : 6'd0, vecs[i].we ? wb_mask : 2'd0,
               done, busy, start_ready, vl};
      exp_v = {vecs[i].rv, vecs[i].ro, vecs[i].rm, vecs[i].we, vecs[i].vo, vecs[i].wm,
               vecs[i].dn, vecs[i].bz, vecs[i].sr, vecs[i].vlo};
      check($sformatf("vec%0d", i), {5'b0, got_v}, {5'b0, exp_v});
      if (i == 1) check("latched_sew_eew", {28'b0, sew, eew}, {28'b0, SEW16, SEW8});
    end

    // Asynchronous reset while beats are in flight (vl=8, offset 4)
    @(negedge CLK); drive(1, 6'd8, 1, 0, 0);
    @(negedge CLK); drive(0, 6'd0, 0, 0, 0);
    @(negedge CLK);
    @(negedge CLK); #1;
    check("pre_reset_offset", {26'b0, rd_offset}, 32'd4);
    check("pre_reset_wen", {31'b0, wen}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("async_rst_outputs", {27'b0, rd_valid, wen, done, busy, start_ready}, 32'h1);
    check("async_rst_fields", {20'b0, rd_offset, vl}, 32'h0);
    check("async_rst_sew", {28'b0, sew, eew}, {28'b0, SEW32, SEW32});
    @(negedge CLK);
    nRST = 1'b1;
    drive(1, 6'd2, 1, 0, 0);
    @(negedge CLK); drive(0, 6'd0, 0, 0, 0); #1;
    check("post_rst_beat", {23'b0, rd_valid, rd_offset, rd_mask}, {23'b0, 1'b1, 6'd0, 2'b11});
    @(negedge CLK); #1;
    check("post_rst_drain", {29'b0, rd_valid, wen, busy}, 32'b001);
    @(negedge CLK); #1;
    check("post_rst_wen", {23'b0, wen, vd_offset, wb_mask}, {23'b0, 1'b1, 6'd0, 2'b11});
    @(negedge CLK); #1;
    check("post_rst_done", {29'b0, done, busy, start_ready}, 32'b101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rv32v_elem_sequencer.md
Name: rv32v_elem_sequencer

Overview:
- Sequences one vector instruction through the vector register file, NUM_LANES elements per beat.
- Accepts a start handshake carrying vl, sew, eew and a write flag. Generates per-beat element offsets and a lane-active mask for the read ports (vs1/vs2/vs3_offset).
- Generates the matching delayed write beat (vd_offset, wen, mask) after a fixed writeback latency.
- Sits between vector decode and the register file; pulses done when the last element has been written back.

Parameters:
- NUM_LANES, 2, elements processed per beat; power of two.
- VL_WIDTH, 5, vl is VL_WIDTH+1 bits wide (max vl 32).
- WB_LATENCY, 2, cycles from read beat to write beat; 1..4.

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- start  input  1  new instruction request
- start_ready  output  1  sequencer can accept start
- vl_in  input  VL_WIDTH+1  element count for instruction
- sew_in  input  sew_t  element width, passed through
- eew_in  input  sew_t  effective width for writeback, passed through
- wr_en_in  input  1  instruction writes vd
- stall  input  1  hold read beat (downstream hazard)
- flush  input  1  abort current instruction
- rd_valid  output  1  read beat valid this cycle
- rd_offset  output  offset_t  element index of lane 0 for vs1/vs2/vs3
- rd_mask  output  NUM_LANES  lane i active iff rd_offset+i < vl
- sew  output  sew_t  latched sew
- eew  output  sew_t  latched eew
- vl  output  VL_WIDTH+1  latched vl
- vd_offset  output  offset_t  write beat element index
- wb_mask  output  NUM_LANES  write lane-active mask
- wen  output  1  write beat enable (valid & latched wr_en)
- busy  output  1  instruction in flight (reads or writes pending)
- done  output  1  one-cycle pulse after final write beat

Behaviour:
- Reset: state IDLE. start_ready=1. rd_valid, wen, busy, done = 0. Offsets, masks, vl = 0. sew/eew = SEW32. Writeback pipe cleared.
- FSM states:
  - IDLE: start_ready=1. On start, latch vl_in/sew_in/eew_in/wr_en_in and set offset=0. Go to RUN if vl_in>0. If vl_in==0, go to DRAIN with empty pipe; done pulses the next cycle and no rd/wen beats occur.
  - RUN: rd_valid=1. A beat is accepted when rd_valid & !stall. On acceptance: push {offset, mask} into the writeback pipe; offset += NUM_LANES. If the accepted beat is last (offset+NUM_LANES >= vl), go to DRAIN. While stall is high, offset and mask hold and a bubble enters the pipe.
  - DRAIN: rd_valid=0. Wait until the pipe is empty, then done=1 for one cycle and go to IDLE.
- Writeback pipe: WB_LATENCY-stage shift register of {valid, offset, mask}; advances every cycle regardless of stall. Stage output drives vd_offset/wb_mask; wen = valid & wr_en.
- Latency: first read beat one cycle after start acceptance. First write beat WB_LATENCY cycles after first accepted read beat. done one cycle after last write beat.
- Offset arithmetic: VL_WIDTH+2 bits internally; no wrap permitted; last-beat test uses unwrapped sum.
- Masks: partial tail only on last beat; full mask on all others.
- busy = (state != IDLE).
- start_ready = 0 outside IDLE; start ignored there.
- done and a new start may coincide: start in the cycle done is high is accepted (state already IDLE).
- Flush in any state: go to IDLE next cycle. Clear the pipe valids so no wen is issued for pending beats. No done pulse. Flush beats start in the same cycle.
- Asynchronous reset mid-instruction: all state returns to reset values immediately.

Decomposition:
- Shared package rv32v_types_pkg holds:
  - seq_state_t enum {IDLE, RUN, DRAIN}
  - NUM_LANES, VL_WIDTH, offset_t, sew_t
  - wb_beat_t struct {valid, offset, mask}
- Sub-module rv32v_wb_delay_line: parameterised shift register of wb_beat_t with synchronous clear (for flush).

Test Plan:
- NUM_LANES=2, WB_LATENCY=2, vl=5, wr_en=1, no stall -> rd_offset 0,2,4 on consecutive cycles; rd_mask 11,11,01; wen beats two cycles later with identical offsets/masks; done 1 cycle after third wen; busy low with done.
- vl=0 start -> no rd_valid, no wen; done pulses 2 cycles after start; start_ready returns 1.
- vl=4, stall high on second beat for 3 cycles -> offset 2 held 3 cycles; write pipe shows 3 bubbles; exactly 2 wen beats total.
- vl=6, flush asserted during second read beat -> IDLE next cycle; no wen after flush; no done; new start accepted the cycle after.
- wr_en=0, vl=3 -> rd beats 0,2 with masks 11,01; wen never asserted; done still pulses.
- nRST dropped mid-RUN (vl=8, offset 4) -> outputs to reset values asynchronously; after release, start with vl=2 runs cleanly from offset 0.
